// File: rtl/dsm_rx_demod.sv
// Receive demodulator for the delta-sigma transmit chain: maps the 1-bit stream to +/-1,
// mixes it with the fs/4 LO, and decimates it through an ORDER-stage CIC by 2**R_LOG2.
module dsm_rx_demod #(
  parameter int R_LOG2 = 6,
  parameter int ORDER  = 3,
  parameter int OUT_W  = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    bit_in,
  input  logic                    bypass_mix,
  output logic signed [OUT_W-1:0] dout,
  output logic                    dout_valid,
  output logic [1:0]              lo_phase
);

  localparam int ACC_W = 2 + ORDER * R_LOG2;

  typedef logic signed [ACC_W-1:0] acc_t;

  logic [1:0]         lo_cnt;
  logic signed [1:0]  lo_val;
  logic signed [1:0]  mix_next;
  logic signed [1:0]  mix_q;
  acc_t               integ [ORDER];
  acc_t               comb_c [ORDER+1];
  acc_t               comb_d [ORDER];
  logic [ORDER:0]     fill;
  logic [R_LOG2-1:0]  dec_cnt;
  logic               strobe;
  logic signed [OUT_W-1:0] dout_next;

  assign lo_phase = lo_cnt;

  // NOTE: every always_comb assigns its outputs first, so no path can hold a stale value (no latch).
  always_comb begin
    lo_val = 2'sd0;
    if (bypass_mix)        lo_val = 2'sd1;
    else if (lo_cnt == 2'd0) lo_val = 2'sd1;
    else if (lo_cnt == 2'd2) lo_val = -2'sd1;
    mix_next = bit_in ? lo_val : -lo_val;
  end

  // fill[k] marks that stage k (mix register, then integrators) holds a real sample since reset;
  // the decimation counter indexes the newest sample held by the last integrator.
  assign strobe = fill[ORDER] && (dec_cnt == R_LOG2'((1 << R_LOG2) - 1));

  always_comb begin
    comb_c[0] = integ[ORDER-1];
    for (int k = 0; k < ORDER; k++) begin
      comb_c[k+1] = comb_c[k] - comb_d[k];
    end
  end

  generate
    if (OUT_W <= ACC_W) begin : g_trunc
      assign dout_next = comb_c[ORDER][ACC_W-1 -: OUT_W];
    end else begin : g_sext
      assign dout_next = OUT_W'(comb_c[ORDER]);
    end
  endgenerate

  // NOTE: state updates use non-blocking assignments so each integrator reads its predecessor's
  // value from before the edge; reset is synchronous and clears every register, integrators included.
  always_ff @(posedge clock) begin
    if (reset) begin
      lo_cnt     <= 2'd0;
      mix_q      <= 2'sd0;
      fill       <= '0;
      dec_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      for (int k = 0; k < ORDER; k++) begin
        integ[k]  <= '0;
        comb_d[k] <= '0;
      end
    end else begin
      lo_cnt     <= lo_cnt + 2'd1;
      mix_q      <= mix_next;
      fill       <= {fill[ORDER-1:0], 1'b1};
      dout_valid <= strobe;
      if (fill[ORDER]) dec_cnt <= dec_cnt + 1'b1;
      // Two's complement wrap is intended; the combs recover the exact block sum.
      integ[0] <= integ[0] + acc_t'(mix_q);
      for (int k = 1; k < ORDER; k++) begin
        integ[k] <= integ[k] + integ[k-1];
      end
      if (strobe) begin
        for (int k = 0; k < ORDER; k++) begin
          comb_d[k] <= comb_c[k];
        end
        dout <= dout_next;
      end
    end
  end

endmodule
